enqueue_agent_v0_2: RTL
=======================

Name: enqueue_agent_v0_2

Overview:
Parametrised admission/enqueue controller for the PIFO scheduler top. It sits between the pipeline's AXI-Stream output and NUM_QUEUES output_queue instances. On each packet's first beat it decodes the SUME destination bitmap and checks per-queue buffer and PIFO fullness. It then latches a per-packet admit mask, drives per-queue buffer write enables for every beat, and pulses per-queue PIFO insert on the last beat. Unlike v0_1 it supports configurable queue count, a selectable multicast drop policy, and drives the stored/dropped statistics outputs.

Parameters:
NUM_QUEUES, 5, number of output queues; the last queue is the CPU/DMA queue.
C_S_AXIS_TUSER_WIDTH, 128, SUME metadata width (PIFO info already stripped).
C_S_AXI_DATA_WIDTH, 32, width of byte/drop counters.
DROP_MODE, 0, 0 = per-queue drop (multicast partially admitted); 1 = all-or-nothing (any target full drops the whole packet).

Ports:
axis_aclk  in  1  clock
axis_resetn  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  1  pipeline beat valid
s_axis_tready  out  1  ready to pipeline
s_axis_tlast  in  1  last beat of packet
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  SUME meta: [15:0] pkt_len bytes, [23:16] src_port, [31:24] dst_port
s_axis_buffer_almost_full  in  NUM_QUEUES  per-queue packet buffer almost full
s_axis_pifo_full  in  NUM_QUEUES  per-queue PIFO full
m_axis_ctl_buffer_wr_en  out  NUM_QUEUES  per-queue buffer write enable, one per accepted beat
m_axis_ctl_pifo_in_en  out  NUM_QUEUES  per-queue PIFO insert strobe
pkt_stored  out  NUM_QUEUES  1-cycle pulse per queue that admitted a packet
bytes_stored  out  C_S_AXI_DATA_WIDTH  pkt_len of the last admitted packet
pkt_dropped  out  NUM_QUEUES  1-cycle pulse per queue that dropped a packet
bytes_dropped  out  C_S_AXI_DATA_WIDTH  pkt_len of the last dropped packet
drop_count  out  C_S_AXI_DATA_WIDTH  cumulative count of per-queue drop events, wraps

Behaviour:
- Reset (axis_resetn=0, asynchronous): state=IDLE, admit mask=0, s_axis_tready=0, and all stats outputs and drop_count are 0. The enable outputs are 0 because tready=0.
- s_axis_tready is registered. It is 1 from the first clock edge after reset deasserts and stays 1; the block never backpressures.
- Beat handshake: hs = s_axis_tvalid & s_axis_tready.
- Queue decode, target[q]:
  - q < NUM_QUEUES-1: dst_port bit 2q.
  - q = NUM_QUEUES-1: OR of all odd dst_port bits.
- Full flag: full[q] = buffer_almost_full[q] | pifo_full[q].
- Admission:
  - DROP_MODE=0: admit = target & ~full.
  - DROP_MODE=1: admit = target if (target & full) == 0, else 0.
  - drop = target & ~admit.
- FSM states IDLE and IN_PKT.
  - IDLE, hs & ~tlast: latch admit, drop and pkt_len; go to IN_PKT.
  - IDLE, hs & tlast (single-beat packet): decide and complete in the same cycle; stay in IDLE.
  - IN_PKT, hs & tlast: go to IDLE.
  - Otherwise hold state.
- Write enables (combinational):
  - In IDLE: m_axis_ctl_buffer_wr_en = hs ? admit_comb : 0.
  - In IN_PKT: m_axis_ctl_buffer_wr_en = hs ? admit_latched : 0.
  - The latched mask is frozen for the whole packet; full-flag changes mid-packet are ignored.
- PIFO insert (combinational): m_axis_ctl_pifo_in_en = hs & tlast ? current admit mask : 0. It fires in the same cycle as the last buffer write.
- Stats, registered one cycle after the EOP handshake:
  - pkt_stored = admit mask; pkt_dropped = drop mask.
  - Pulses last exactly 1 cycle, otherwise 0.
  - bytes_stored is updated to pkt_len only if admit is nonzero; bytes_dropped only if drop is nonzero. Both hold otherwise.
  - drop_count += popcount(drop), modulo 2^C_S_AXI_DATA_WIDTH.
- dst_port=0 (no target): the packet is consumed silently. No enables fire, nothing is counted as stored or dropped.
- tvalid low mid-packet: state and mask hold, no enables fire.
- Reset mid-packet: everything clears immediately. The next beat after reset is treated as SOP; upstream is reset concurrently.

Test Plan:
- NUM_QUEUES=5, DROP_MODE=0, all flags 0, 3-beat packet dst=0x04, len=150 → wr_en=5'b00010 on beats 1-3, pifo_in_en=00010 on beat 3, next cycle pkt_stored=00010, bytes_stored=150.
- Single-beat packet (tlast on first beat) dst=0x02, len=60 → wr_en=pifo_in_en=5'b10000 in the same cycle, pkt_stored=10000 next cycle, FSM remains IDLE.
- DROP_MODE=0, multicast dst=0x05, buffer_almost_full=00010 → wr_en=00001 every beat, pkt_dropped=00010, bytes_dropped=len, drop_count +1; repeat with DROP_MODE=1 → wr_en=0, pkt_dropped=00011, drop_count +2.
- pifo_full[0] rises after SOP of a 4-beat packet to queue 0 → wr_en[0] is still 1 on all 4 beats and pifo_in_en[0] pulses on beat 4 (mask frozen).
- tvalid gaps of 2 cycles between beats, plus axis_resetn asserted on beat 2 of 3 → no enables during the gaps; on reset, outputs go to 0 immediately; after release tready=1 on the next edge and the next beat is decoded as SOP.
- drop_count preloaded near wrap via 2^32-1 drop events (or a reduced-width build with C_S_AXI_DATA_WIDTH=4 and 16 drops) → counter wraps to 0.

Source files
------------

// File: rtl/enqueue_agent_v0_2.sv
// Admission/enqueue controller feeding NUM_QUEUES output queues.
// On the first beat of each packet the SUME destination bitmap and the
// per-queue fullness flags decide which queues take the packet. That
// decision is frozen for the rest of the packet. It drives the per-beat
// buffer writes, the last-beat PIFO insert and the stored/dropped statistics.
//
// Handshake: a beat transfers when s_axis_tvalid and s_axis_tready are both
// high on a rising clock edge. s_axis_tready is registered: it rises on the
// first edge after reset release and then stays high, so the block never
// backpressures. Write and insert enables are combinational in the transfer
// cycle and are low whenever no transfer happens.
module enqueue_agent_v0_2 #(
  parameter int NUM_QUEUES           = 5,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int DROP_MODE            = 0
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]           s_axis_buffer_almost_full,
  input  logic [NUM_QUEUES-1:0]           s_axis_pifo_full,
  output logic [NUM_QUEUES-1:0]           m_axis_ctl_buffer_wr_en,
  output logic [NUM_QUEUES-1:0]           m_axis_ctl_pifo_in_en,
  output logic [NUM_QUEUES-1:0]           pkt_stored,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bytes_stored,
  output logic [NUM_QUEUES-1:0]           pkt_dropped,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   bytes_dropped,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   drop_count,
  output logic                            o_dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t                          r_state;
  logic                            r_tready;
  logic [NUM_QUEUES-1:0]           r_admit;
  logic [NUM_QUEUES-1:0]           r_drop;
  logic [15:0]                     r_pkt_len;
  logic [NUM_QUEUES-1:0]           r_pkt_stored;
  logic [NUM_QUEUES-1:0]           r_pkt_dropped;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_bytes_stored;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_bytes_dropped;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_drop_count;

  logic                            w_hs;
  logic                            w_eop;
  logic [15:0]                     w_pkt_len;
  logic [7:0]                      w_dst_port;
  logic [NUM_QUEUES-1:0]           w_target;
  logic [NUM_QUEUES-1:0]           w_full;
  logic [NUM_QUEUES-1:0]           w_admit;
  logic [NUM_QUEUES-1:0]           w_drop;
  logic [NUM_QUEUES-1:0]           w_cur_admit;
  logic [NUM_QUEUES-1:0]           w_cur_drop;
  logic [15:0]                     w_cur_len;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_drop_pop;
  logic                            w_tuser_unused;

  assign w_hs       = s_axis_tvalid & r_tready;
  assign w_eop      = w_hs & s_axis_tlast;
  assign w_pkt_len  = s_axis_tuser[15:0];
  assign w_dst_port = s_axis_tuser[31:24];
  // src_port and the upper metadata are carried through but not used here.
  assign w_tuser_unused = ^{s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:32], s_axis_tuser[23:16]};

  // Even dst_port bits select the regular queues in order; any odd bit
  // (a CPU port) targets the last queue.
  for (genvar g = 0; g < NUM_QUEUES - 1; g++) begin : g_target
    if (2 * g < 8) begin : g_bit
      assign w_target[g] = w_dst_port[2*g];
    end else begin : g_none
      assign w_target[g] = 1'b0;
    end
  end
  assign w_target[NUM_QUEUES-1] = |(w_dst_port & 8'hAA);

  assign w_full = s_axis_buffer_almost_full | s_axis_pifo_full;

  // Admission decision for a packet starting this cycle.
  always_comb begin
    w_admit = '0;
    if (DROP_MODE == 0) begin
      w_admit = w_target & ~w_full;
    end else if ((w_target & w_full) == '0) begin
      w_admit = w_target;
    end
    w_drop = w_target & ~w_admit;
  end

  // Mask in force for the current beat: fresh decision at SOP, latched after.
  always_comb begin
    w_cur_admit = r_admit;
    w_cur_drop  = r_drop;
    w_cur_len   = r_pkt_len;
    if (r_state == IDLE) begin
      w_cur_admit = w_admit;
      w_cur_drop  = w_drop;
      w_cur_len   = w_pkt_len;
    end
  end

  assign w_drop_pop = C_S_AXI_DATA_WIDTH'($countones(w_cur_drop));

  assign m_axis_ctl_buffer_wr_en = w_hs  ? w_cur_admit : '0;
  assign m_axis_ctl_pifo_in_en   = w_eop ? w_cur_admit : '0;

  // Packet FSM: latches the admission mask at SOP of multi-beat packets.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state   <= IDLE;
      r_tready  <= 1'b0;
      r_admit   <= '0;
      r_drop    <= '0;
      r_pkt_len <= '0;
    end else begin
      r_tready <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_hs && !s_axis_tlast) begin
            r_admit   <= w_admit;
            r_drop    <= w_drop;
            r_pkt_len <= w_pkt_len;
            r_state   <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (w_eop) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Statistics, reported on the cycle after the last beat transfers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_pkt_stored    <= '0;
      r_pkt_dropped   <= '0;
      r_bytes_stored  <= '0;
      r_bytes_dropped <= '0;
      r_drop_count    <= '0;
    end else begin
      r_pkt_stored  <= w_eop ? w_cur_admit : '0;
      r_pkt_dropped <= w_eop ? w_cur_drop  : '0;
      if (w_eop && (|w_cur_admit)) begin
        r_bytes_stored <= C_S_AXI_DATA_WIDTH'(w_cur_len);
      end
      if (w_eop && (|w_cur_drop)) begin
        r_bytes_dropped <= C_S_AXI_DATA_WIDTH'(w_cur_len);
      end
      if (w_eop) begin
        r_drop_count <= r_drop_count + w_drop_pop;
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign pkt_stored    = r_pkt_stored;
  assign pkt_dropped   = r_pkt_dropped;
  assign bytes_stored  = r_bytes_stored;
  assign bytes_dropped = r_bytes_dropped;
  assign drop_count    = r_drop_count;
  assign o_dbg_state   = r_state;

endmodule
